// File: rtl/apb_cmd_sequencer_if.sv
// apb_cmd_sequencer_if
// Groups the host request/response handshake and the APB master bus of the
// command sequencer into one bundle.
//   master : sequencer view (drives req_ready, rsp_*, PSEL/PENABLE/PWRITE/PWDATA)
//   slave  : environment view (host plus APB slave; drives req_*, PRDATA, PREADY)
interface apb_cmd_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_poll;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_code;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        input  req_valid, req_write, req_poll, req_wdata, PRDATA, PREADY,
        output req_ready, rsp_valid, rsp_rdata, rsp_code,
               PSEL, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_poll, req_wdata, PRDATA, PREADY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_code,
               PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_cmd_sequencer.sv
// apb_cmd_sequencer
// APB master that performs one host request at a time: a write to the slave's
// command register or a read of its status register, optionally followed by
// status polling until DONE_BIT is set. PREADY wait states are bounded by a
// timeout.
//   pclk : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : apb_cmd_sequencer_if.master (host handshake + APB master signals)
//
// state       | meaning
// ------------+---------------------------------------------------
// IDLE        | waiting for a host request, req_ready high
// SETUP       | APB setup phase of the requested transfer
// ACCESS      | APB access phase, waiting for PREADY
// POLL_SETUP  | setup phase of a status read while polling
// POLL_ACCESS | access phase of a status read while polling
// RESP        | one-cycle response pulse to the host
module apb_cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int POLL_LIMIT     = 8,
    parameter int DONE_BIT       = 31
) (
    input  logic                 pclk,
    input  logic                 rst,
    apb_cmd_sequencer_if.master  bus
);

    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = $clog2(POLL_LIMIT + 1);
    localparam logic [WW-1:0] WAIT_INIT = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST   = RW'(POLL_LIMIT - 1);

    localparam logic [1:0] CODE_OK      = 2'b00;
    localparam logic [1:0] CODE_TIMEOUT = 2'b01;
    localparam logic [1:0] CODE_POLL    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_POLL_SETUP,
        S_POLL_ACCESS,
        S_RESP
    } state_t;

    state_t        state, state_nxt;
    logic          wr_q, poll_q;
    logic [31:0]   wdata_q, rdata_q;
    logic [31:0]   rsp_rdata_q;
    logic [1:0]    rsp_code_q;
    logic [WW-1:0] wait_cnt;
    logic [RW-1:0] rd_cnt;

    logic          accept, wait_load, wait_dec, rd_inc, capture, rsp_load;
    logic [1:0]    code_nxt;
    logic          psel, penable, pwrite;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        wait_load = 1'b0;
        wait_dec  = 1'b0;
        rd_inc    = 1'b0;
        capture   = 1'b0;
        rsp_load  = 1'b0;
        code_nxt  = CODE_OK;
        psel      = 1'b0;
        penable   = 1'b0;
        pwrite    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    wait_load = 1'b1;
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                psel      = 1'b1;
                pwrite    = wr_q;
                state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                pwrite  = wr_q;
                if (bus.PREADY) begin
                    capture = !wr_q;
                    if (wr_q && poll_q) begin
                        wait_load = 1'b1;
                        state_nxt = S_POLL_SETUP;
                    end else begin
                        rsp_load  = 1'b1;
                        state_nxt = S_RESP;
                    end
                end else if (wait_cnt == '0) begin
                    rsp_load  = 1'b1;
                    code_nxt  = CODE_TIMEOUT;
                    state_nxt = S_RESP;
                end else begin
                    wait_dec = 1'b1;
                end
            end
            S_POLL_SETUP: begin
                psel      = 1'b1;
                state_nxt = S_POLL_ACCESS;
            end
            S_POLL_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (bus.PREADY) begin
                    capture = 1'b1;
                    rd_inc  = 1'b1;
                    if (bus.PRDATA[DONE_BIT]) begin
                        rsp_load  = 1'b1;
                        state_nxt = S_RESP;
                    end else if (rd_cnt == RD_LAST) begin
                        rsp_load  = 1'b1;
                        code_nxt  = CODE_POLL;
                        state_nxt = S_RESP;
                    end else begin
                        wait_load = 1'b1;
                        state_nxt = S_POLL_SETUP;
                    end
                end else if (wait_cnt == '0) begin
                    rsp_load  = 1'b1;
                    code_nxt  = CODE_TIMEOUT;
                    state_nxt = S_RESP;
                end else begin
                    wait_dec = 1'b1;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // The wait timer is a down-counter loaded on entry to each setup phase;
    // reaching zero with PREADY still low marks the last allowed wait cycle.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state       <= S_IDLE;
            wr_q        <= 1'b0;
            poll_q      <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_code_q  <= CODE_OK;
            wait_cnt    <= '0;
            rd_cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wr_q    <= bus.req_write;
                poll_q  <= bus.req_write & bus.req_poll;
                wdata_q <= bus.req_wdata;
                rdata_q <= '0;
                rd_cnt  <= '0;
            end
            if (wait_load) begin
                wait_cnt <= WAIT_INIT;
            end else if (wait_dec) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (rd_inc) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (capture) begin
                rdata_q <= bus.PRDATA;
            end
            // Response fields update only on the way into RESP so they hold
            // between responses; the completing read's data bypasses rdata_q.
            if (rsp_load) begin
                rsp_rdata_q <= capture ? bus.PRDATA : rdata_q;
                rsp_code_q  <= code_nxt;
            end
        end
    end

    assign bus.req_ready = (state == S_IDLE) && !rst;
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_code  = rsp_code_q;
    assign bus.PSEL      = psel;
    assign bus.PENABLE   = penable;
    assign bus.PWRITE    = pwrite;
    assign bus.PWDATA    = wdata_q;

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// tb_apb_cmd_sequencer
// Directed bench: a scripted APB slave, a stimulus process that pushes the
// expected response of each accepted request into a scoreboard queue, and a
// monitor that tracks the bus during each transfer and checks every response.
module tb_apb_cmd_sequencer;

    typedef struct {
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  code;
        int          lat;
        int          nwr;
        int          nrd;
    } exp_t;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    int   cyc  = 0;
    int   tests = 0;
    int   fails = 0;

    exp_t        exp_q[$];
    int          slv_waits[$];
    logic [31:0] slv_data[$];

    apb_cmd_sequencer_if bus();

    apb_cmd_sequencer #(
        .TIMEOUT_CYCLES(16),
        .POLL_LIMIT(8),
        .DONE_BIT(31)
    ) dut (
        .pclk(pclk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scripted slave: drives PREADY/PRDATA 1 time unit after each edge.
    // Junk data during wait states and outside ACCESS catches mis-timed capture.
    always @(posedge pclk) begin
        #1;
        if (bus.PSEL && bus.PENABLE) begin
            if (slv_waits.size() == 0) begin
                bus.PREADY = 1'b0;
                bus.PRDATA = 32'hDEAD_BEEF;
            end else if (slv_waits[0] > 0) begin
                bus.PREADY   = 1'b0;
                bus.PRDATA   = 32'hDEAD_BEEF;
                slv_waits[0] = slv_waits[0] - 1;
            end else begin
                bus.PREADY = 1'b1;
                bus.PRDATA = slv_data[0];
                void'(slv_waits.pop_front());
                void'(slv_data.pop_front());
            end
        end else begin
            bus.PREADY = 1'b1;
            bus.PRDATA = 32'hFFFF_FFFF;
        end
    end

    // Monitor: sampled mid-cycle on the falling edge.
    exp_t cur;
    exp_t e;
    bit   busy = 1'b0;
    bit   gap, pwd_bad;
    int   acc, first_psel, first_pen, nwr, nrd;

    always @(negedge pclk) begin
        if (rst) begin
            busy = 1'b0;
        end else begin
            if (busy) begin
                if (bus.PSEL) begin
                    if (first_psel < 0) first_psel = cyc;
                    if (bus.PENABLE && first_pen < 0) first_pen = cyc;
                    if (bus.PWDATA !== cur.wdata) pwd_bad = 1'b1;
                    if (bus.PENABLE && bus.PREADY) begin
                        if (bus.PWRITE) nwr++;
                        else nrd++;
                    end
                end else if (!bus.rsp_valid && first_psel >= 0) begin
                    gap = 1'b1;
                end
            end
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0 || !busy) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_code", 32'(bus.rsp_code), 32'(e.code));
                    chk("rsp_latency", 32'(cyc - acc), 32'(e.lat));
                    chk("write_xfers", 32'(nwr), 32'(e.nwr));
                    chk("read_xfers", 32'(nrd), 32'(e.nrd));
                    chk("setup_cycle", 32'(first_psel - acc), 32'd1);
                    chk("access_cycle", 32'(first_pen - acc), 32'd2);
                    chk("psel_gap", 32'(gap), 32'd0);
                    chk("pwdata_stable", 32'(pwd_bad), 32'd0);
                    chk("psel_in_resp", 32'(bus.PSEL), 32'd0);
                    busy = 1'b0;
                end
            end
            if (bus.req_valid && bus.req_ready && exp_q.size() > 0) begin
                cur        = exp_q[0];
                busy       = 1'b1;
                acc        = cyc;
                first_psel = -1;
                first_pen  = -1;
                nwr        = 0;
                nrd        = 0;
                gap        = 1'b0;
                pwd_bad    = 1'b0;
            end
        end
    end

    int acc_stim;

    task automatic slv(input int waits, input logic [31:0] data);
        slv_waits.push_back(waits);
        slv_data.push_back(data);
    endtask

    // Called 2 time units after an edge; returns at the same offset one cycle
    // after acceptance.
    task automatic issue(input logic w, input logic p, input logic [31:0] d,
                         input logic [31:0] erd, input logic [1:0] ecode,
                         input int elat, input int enwr, input int enrd,
                         input bit hold);
        exp_t x;
        x.wdata = d;
        x.rdata = erd;
        x.code  = ecode;
        x.lat   = elat;
        x.nwr   = enwr;
        x.nrd   = enrd;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_poll  = p;
        bus.req_wdata = d;
        for (int i = 0; i < 200; i++) begin
            if (bus.req_ready) begin
                exp_q.push_back(x);
                acc_stim = cyc;
                @(posedge pclk);
                #2;
                if (!hold) bus.req_valid = 1'b0;
                return;
            end
            @(posedge pclk);
            #2;
        end
        tests++;
        fails++;
        $display("FAIL accept_timeout: got req_ready=0 for 200 cycles expected 1");
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) begin
                slv_waits.delete();
                slv_data.delete();
                return;
            end
            @(posedge pclk);
            #2;
        end
        tests++;
        fails++;
        $display("FAIL rsp_timeout: got %0d pending responses expected 0", exp_q.size());
        exp_q.delete();
        slv_waits.delete();
        slv_data.delete();
    endtask

    int acc_first;
    bit seen;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_poll  = 1'b0;
        bus.req_wdata = '0;
        bus.PREADY    = 1'b1;
        bus.PRDATA    = '0;

        repeat (3) @(posedge pclk);
        #2;
        chk("rst_psel", 32'(bus.PSEL), 32'd0);
        chk("rst_penable", 32'(bus.PENABLE), 32'd0);
        chk("rst_pwrite", 32'(bus.PWRITE), 32'd0);
        chk("rst_pwdata", bus.PWDATA, 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_code", 32'(bus.rsp_code), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        @(posedge pclk);
        #2;
        chk("idle_req_ready", 32'(bus.req_ready), 32'd1);

        // Read, PREADY never rises: 16 ACCESS cycles then timeout response.
        slv(1000, 32'h1111_1111);
        issue(1'b0, 1'b0, 32'hA5A5_0001, 32'h0, 2'b01, 18, 0, 0, 1'b0);
        wait_done();

        // Read completing on the 16th ACCESS cycle: completion wins.
        slv(15, 32'h0BAD_CAFE);
        issue(1'b0, 1'b0, 32'hA5A5_0002, 32'h0BAD_CAFE, 2'b00, 18, 0, 1, 1'b0);
        wait_done();

        // Zero-wait write; slave data must not reach rsp_rdata.
        slv(0, 32'h9234_5678);
        issue(1'b1, 1'b0, 32'h8000_0000, 32'h0, 2'b00, 3, 1, 0, 1'b0);
        wait_done();

        // Read with two wait states.
        slv(2, 32'h7FFF_FFFF);
        issue(1'b0, 1'b0, 32'h0000_0000, 32'h7FFF_FFFF, 2'b00, 5, 0, 1, 1'b0);
        wait_done();

        // Write + poll, done on third status read.
        slv(0, 32'h9234_5678);
        slv(0, 32'h0000_0000);
        slv(0, 32'h0000_0000);
        slv(0, 32'h8000_0000);
        issue(1'b1, 1'b1, 32'h0000_00C3, 32'h8000_0000, 2'b00, 9, 1, 3, 1'b0);
        wait_done();

        // Write + poll, done bit never set: exactly 8 reads.
        slv(0, 32'h0000_1234);
        for (int i = 0; i < 8; i++) slv(0, (i == 7) ? 32'h7FFF_0055 : 32'(i));
        issue(1'b1, 1'b1, 32'h0000_0A0A, 32'h7FFF_0055, 2'b10, 19, 1, 8, 1'b0);
        wait_done();

        // req_poll on a read is ignored.
        slv(0, 32'h0000_0042);
        issue(1'b0, 1'b1, 32'h0000_0077, 32'h0000_0042, 2'b00, 3, 0, 1, 1'b0);
        wait_done();

        // Back-to-back with req_valid held through the busy period.
        slv(0, 32'h0000_0000);
        slv(0, 32'h2222_2222);
        issue(1'b1, 1'b0, 32'h1111_1111, 32'h0, 2'b00, 3, 1, 0, 1'b1);
        acc_first = acc_stim;
        issue(1'b0, 1'b0, 32'h3333_3333, 32'h2222_2222, 2'b00, 3, 0, 1, 1'b0);
        chk("b2b_spacing", 32'(acc_stim - acc_first), 32'd4);
        wait_done();

        // Reset during ACCESS of a poll read.
        slv(0, 32'h0000_0000);
        slv(5, 32'h8000_0000);
        issue(1'b1, 1'b1, 32'h0000_5555, 32'h8000_0000, 2'b00, 13, 1, 1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.PSEL && bus.PENABLE && !bus.PWRITE) begin
                seen = 1'b1;
                break;
            end
            @(posedge pclk);
            #2;
        end
        chk("poll_access_seen", 32'(seen), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge pclk);
        #2;
        chk("mid_rst_psel", 32'(bus.PSEL), 32'd0);
        chk("mid_rst_penable", 32'(bus.PENABLE), 32'd0);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
        slv_waits.delete();
        slv_data.delete();
        @(posedge pclk);
        #2;
        rst = 1'b0;
        @(posedge pclk);
        #2;
        chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        repeat (4) begin
            @(posedge pclk);
            #2;
        end
        slv(0, 32'h0000_0000);
        issue(1'b1, 1'b0, 32'h3C3C_3C3C, 32'h0, 2'b00, 3, 1, 0, 1'b0);
        wait_done();

        repeat (3) @(posedge pclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_cmd_sequencer.md
# apb_cmd_sequencer

APB master-side sequencer that drives the single-register APB slave interface (command register on write, status register on read) on behalf of an internal host. It accepts one request at a time over a valid/ready handshake, generates compliant SETUP/ACCESS phases, tolerates PREADY wait states with a timeout, and can optionally poll the status register after a command write until a done bit is set. It sits between the control logic and the APB bus in front of the slave.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, max consecutive ACCESS cycles with PREADY low before abort (>=1)
- POLL_LIMIT, 8, max status reads in poll mode (>=1)
- DONE_BIT, 31, status bit index that signals command completion

Ports:
- pclk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  host request present
- req_ready  out  1  sequencer idle and able to accept
- req_write  in  1  1 = write command register, 0 = read status register
- req_poll  in  1  with req_write=1: poll status after the write
- req_wdata  in  32  command word
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  last PRDATA captured (0 for a plain write)
- rsp_code  out  2  00 ok, 01 wait timeout, 10 poll limit exhausted, 11 unused
- PSEL, PENABLE, PWRITE  out  1 each  APB master controls
- PWDATA  out  32  APB write data
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready; tie to 1 for zero-wait slaves

## Operation
- States: IDLE, SETUP, ACCESS, POLL_SETUP, POLL_ACCESS, RESP.
- IDLE: req_ready=1 (forced 0 while rst high). Accept on the edge with req_valid & req_ready; latch req_write, req_poll, req_wdata; go to SETUP. req_poll ignored when req_write=0.
- SETUP: PSEL=1, PENABLE=0, PWRITE=latched write, PWDATA=latched data; always to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. On PREADY=1: for a read, capture PRDATA; go to POLL_SETUP if write with poll, else RESP code 00. On PREADY=0: increment wait counter.
- POLL_SETUP/POLL_ACCESS: same as SETUP/ACCESS with PWRITE=0; read counter increments on each completed read. On completion: PRDATA[DONE_BIT]=1 -> RESP code 00; else if reads == POLL_LIMIT -> RESP code 10; else POLL_SETUP.
- Wait timeout (either ACCESS state): PREADY=0 on the TIMEOUT_CYCLES-th consecutive ACCESS cycle -> RESP code 01, PSEL/PENABLE drop next cycle. PREADY=1 on that cycle is a normal completion (completion wins).
- Wait counter clears on entry to every SETUP/POLL_SETUP; read counter clears on request acceptance.
- RESP: PSEL=0, PENABLE=0, rsp_valid=1 for exactly one cycle, rsp_rdata/rsp_code valid; back to IDLE.
- PWDATA and PWRITE stable for the full transfer; PWDATA holds the command word through poll reads.
- rsp_rdata/rsp_code hold their values until the next RESP.
- Requests while busy are not accepted (req_ready=0); the host holds them.

## Timing
- Reset values (edge with rst=1): state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_code=00, counters 0.
- rst mid-transfer: next cycle all bus outputs 0, no rsp_valid for the aborted request.
- Acceptance edge = cycle 0; SETUP cycle 1; ACCESS cycle 2; zero-wait completion -> rsp_valid cycle 3. Each wait state adds one cycle.
- Poll: completion cycle of one transfer is followed directly by POLL_SETUP (PSEL stays 1, PENABLE drops); each zero-wait read costs 2 cycles.
- Earliest next acceptance: cycle after RESP (IDLE). Plain zero-wait throughput: one request per 4 cycles.
- Timeout abort: rsp_valid exactly TIMEOUT_CYCLES+1 cycles after SETUP.

## Test plan
- Write 0x8000_0000, PREADY=1 -> PSEL cycle 1, PENABLE cycle 2, PWRITE=1, PWDATA=0x8000_0000, rsp_valid cycle 3, code 00, rsp_rdata 0.
- Read, PREADY low 2 ACCESS cycles then high with PRDATA=0x7FFF_FFFF -> rsp_valid cycle 5, rsp_rdata 0x7FFF_FFFF, code 00.
- Read, PREADY held 0, TIMEOUT_CYCLES=16 -> 16 ACCESS cycles, PSEL=0 and rsp_valid at cycle 18, code 01; PREADY rising on cycle 16 instead -> code 00.
- Write+poll, status 0x0, 0x0, 0x8000_0000 -> 1 write plus 3 reads, PSEL continuous, rsp_rdata 0x8000_0000, code 00.
- Write+poll, status never sets bit 31, POLL_LIMIT=8 -> exactly 8 reads, code 10, rsp_rdata = last PRDATA.
- rst high during ACCESS of a poll read -> next cycle PSEL=PENABLE=0, no rsp_valid; after rst low, req_ready=1 and a new write completes normally; req_valid during busy is not accepted.
